// File: rtl/punct_sched_if.sv
// punct_sched_if: scheduler <-> encoder / matcher / interleaver handshake bundle.
// master = scheduler side (drives run and cr), slave = datapath side.
interface punct_sched_if;
  // Handshake: a pair advances on every cycle with run high. The scheduler raises
  // run only inside a symbol and only while src_ready and dn_ready are both high.
  // pm_valid marks a run cycle on which the matcher emitted a coded pair.
  // pm_valid carries no meaning on cycles where run is low.
  logic       src_ready;
  logic       dn_ready;
  logic       pm_valid;
  logic       run;
  logic [1:0] cr;

  modport master (input src_ready, dn_ready, pm_valid, output run, cr);
  modport slave  (output src_ready, dn_ready, pm_valid, input run, cr);
endinterface

// File: rtl/punct_sched.sv
// punct_sched: sequences the 802.11a Tx puncturer through SIGNAL then N DATA symbols.
// Build macro PUNCT_ALIGN_CHECK_EN enables the per-symbol NDBPS alignment check on align_err.
module punct_sched #(
  parameter int NSYM_W    = 10,
  parameter int SIG_PAIRS = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        rate,
  input  logic [NSYM_W-1:0] n_sym,
  punct_sched_if.master     pm,
  output logic              field,
  output logic              sym_start,
  output logic              sym_end,
  output logic [NSYM_W-1:0] sym_idx,
  output logic              busy,
  output logic              done,
  output logic              rate_err,
  output logic              align_err,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SIG = 2'd1, S_DATA = 2'd2, S_DONE = 2'd3} state_t;

  function automatic logic rate_ok(input logic [3:0] r);
    case (r)
      4'b1101, 4'b1111, 4'b0101, 4'b0111,
      4'b1001, 4'b1011, 4'b0001, 4'b0011: rate_ok = 1'b1;
      default:                            rate_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] rate_cr(input logic [3:0] r);
    case (r)
      4'b0001:                            rate_cr = 2'b01;
      4'b1111, 4'b0111, 4'b1011, 4'b0011: rate_cr = 2'b10;
      default:                            rate_cr = 2'b00;
    endcase
  endfunction

  function automatic logic [7:0] rate_pairs(input logic [3:0] r);
    case (r)
      4'b1101, 4'b1111: rate_pairs = 8'd24;
      4'b0101, 4'b0111: rate_pairs = 8'd48;
      4'b1001, 4'b1011: rate_pairs = 8'd96;
      4'b0001, 4'b0011: rate_pairs = 8'd144;
      default:          rate_pairs = 8'd24;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        rate_q;
  logic [NSYM_W-1:0] n_sym_q;
  logic [7:0]        pair_cnt;
  logic              first_flag;
  logic [1:0]        cr_q;
  logic              run_c;
  logic              start_acc;
  logic              last_sym;
  logic [7:0]        term_c;

  always_comb begin
    state_d   = state_q;
    run_c     = 1'b0;
    sym_start = 1'b0;
    sym_end   = 1'b0;
    done      = 1'b0;
    start_acc = 1'b0;
    term_c    = (state_q == S_SIG) ? 8'(SIG_PAIRS - 1) : (rate_pairs(rate_q) - 8'd1);
    last_sym  = (state_q == S_SIG) ? (n_sym_q == '0) : (sym_idx == n_sym_q - NSYM_W'(1));
    case (state_q)
      S_IDLE: begin
        start_acc = start & rate_ok(rate);
        if (start_acc) state_d = S_SIG;
      end
      S_SIG, S_DATA: begin
        run_c     = pm.src_ready & pm.dn_ready;
        sym_start = run_c & first_flag & (pair_cnt == 8'd0);
        sym_end   = run_c & pm.pm_valid & (pair_cnt == term_c);
        if (sym_end) state_d = last_sym ? S_DONE : S_DATA;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rate_q     <= 4'd0;
      n_sym_q    <= '0;
      pair_cnt   <= 8'd0;
      first_flag <= 1'b0;
      cr_q       <= 2'b00;
      field      <= 1'b0;
      sym_idx    <= '0;
      busy       <= 1'b0;
      rate_err   <= 1'b0;
    end else begin
      rate_err <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_acc) begin
            rate_q     <= rate;
            n_sym_q    <= n_sym;
            cr_q       <= 2'b00;
            field      <= 1'b0;
            sym_idx    <= '0;
            pair_cnt   <= 8'd0;
            first_flag <= 1'b1;
            busy       <= 1'b1;
          end else if (start) begin
            rate_err <= 1'b1;
          end
        end
        S_SIG, S_DATA: begin
          if (run_c) begin
            first_flag <= sym_end;
            if (pm.pm_valid) pair_cnt <= sym_end ? 8'd0 : pair_cnt + 8'd1;
            // cr moves only here, so the matcher sees a new rate exactly at a symbol edge
            if (sym_end && !last_sym) begin
              if (state_q == S_SIG) begin
                field   <= 1'b1;
                cr_q    <= rate_cr(rate_q);
                sym_idx <= '0;
              end else begin
                sym_idx <= sym_idx + NSYM_W'(1);
              end
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          field <= 1'b0;
          cr_q  <= 2'b00;
        end
        default: ;
      endcase
    end
  end

`ifdef PUNCT_ALIGN_CHECK_EN
  function automatic logic [7:0] rate_ndbps(input logic [3:0] r);
    case (r)
      4'b1101: rate_ndbps = 8'd24;
      4'b1111: rate_ndbps = 8'd36;
      4'b0101: rate_ndbps = 8'd48;
      4'b0111: rate_ndbps = 8'd72;
      4'b1001: rate_ndbps = 8'd96;
      4'b1011: rate_ndbps = 8'd144;
      4'b0001: rate_ndbps = 8'd192;
      4'b0011: rate_ndbps = 8'd216;
      default: rate_ndbps = 8'd24;
    endcase
  endfunction

  logic [7:0] info_cnt;
  logic [8:0] ndbps_exp;
  logic       align_q;

  // SIGNAL always carries 24 data bits regardless of the frame rate
  always_comb ndbps_exp = (state_q == S_SIG) ? 9'd24 : {1'b0, rate_ndbps(rate_q)};

  always_ff @(posedge clk) begin
    if (rst) begin
      info_cnt <= 8'd0;
      align_q  <= 1'b0;
    end else if (start_acc) begin
      info_cnt <= 8'd0;
      align_q  <= 1'b0;
    end else if (run_c) begin
      if (sym_end) begin
        info_cnt <= 8'd0;
        if (({1'b0, info_cnt} + 9'd1) != ndbps_exp) align_q <= 1'b1;
      end else begin
        info_cnt <= info_cnt + 8'd1;
      end
    end
  end

  assign align_err = align_q;
`else
  assign align_err = 1'b0;
`endif

  assign pm.run    = run_c;
  assign pm.cr     = cr_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_punct_sched.sv
// tb_punct_sched: table-driven frame vectors plus directed reset / error sequences for punct_sched.
module tb_punct_sched;
  localparam int NSYM_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [3:0]        rate;
  logic [NSYM_W-1:0] n_sym;
  logic              field, sym_start, sym_end, busy, done, rate_err, align_err;
  logic [NSYM_W-1:0] sym_idx;
  logic [1:0]        state_dbg;

  punct_sched_if pif();

  punct_sched #(.NSYM_W(NSYM_W), .SIG_PAIRS(24)) dut (
    .clk(clk), .rst(rst), .start(start), .rate(rate), .n_sym(n_sym), .pm(pif),
    .field(field), .sym_start(sym_start), .sym_end(sym_end), .sym_idx(sym_idx),
    .busy(busy), .done(done), .rate_err(rate_err), .align_err(align_err),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] rate;
    int         n;
    int         pairs;
    logic [1:0] cr_data;
    int         mode;       // 0 ready always, 1 dn_ready toggles, 2 random readies
    bit         pm_force;   // pm_valid tied high regardless of rate
    bit         poke;       // extra start pulse while busy
    int         exp_runs;
    bit         exp_align;
  } vec_t;

  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  logic [NSYM_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0;
    pif.src_ready = 1'b0;
    pif.dn_ready  = 1'b0;
    pif.pm_valid  = 1'b0;
  endtask

  // driver + cycle model for one frame
  task automatic run_frame(input vec_t v, input string tag);
    int   m_sym, m_pairs, phase, cyc, tail, runs, dones, term;
    int   run_mm, ss_mm, se_mm, done_mm, cr_mm, fld_mm, idx_mm, rerr_mm, busy_mm;
    bit   m_active, m_first, m_done_next, exp_run, exp_end, exp_ss, exp_done, pmv, s, d;
    logic [1:0]        m_cr;
    logic [NSYM_W-1:0] e;
    bit   exp_al;
    exp_q.delete();
    exp_q.push_back('0);
    for (int k = 0; k < v.n; k++) exp_q.push_back(NSYM_W'(k));
    {run_mm, ss_mm, se_mm, done_mm, cr_mm, fld_mm, idx_mm, rerr_mm, busy_mm} = '0;
    runs = 0; dones = 0; tail = 0; cyc = 0;

    start = 1'b1; rate = v.rate; n_sym = NSYM_W'(v.n);
    pif.src_ready = 1'b1; pif.dn_ready = 1'b1; pif.pm_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_on"}, busy, 1);
    check({tag, "_state_sig"}, state_dbg, 1);
    check({tag, "_align_clr"}, align_err, 0);
    check({tag, "_field_sig"}, field, 0);

    m_active = 1; m_first = 1; m_sym = 0; m_pairs = 0; phase = 0; m_done_next = 0;
    while (cyc < 4000) begin
      case (v.mode)
        1:       begin s = 1; d = cyc[0]; end
        2:       begin s = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1)); end
        default: begin s = 1; d = 1; end
      endcase
      exp_run = m_active & s & d;
      m_cr = (m_sym == 0) ? 2'b00 : v.cr_data;
      if (!exp_run)                            pmv = 1'($urandom_range(0, 1));
      else if (v.pm_force || m_cr == 2'b00)    pmv = 1;
      else                                     pmv = (phase != 1);
      if (v.poke && cyc == 10) begin start = 1'b1; rate = 4'b1011; n_sym = NSYM_W'(7); end
      pif.src_ready = s; pif.dn_ready = d; pif.pm_valid = pmv;

      @(negedge clk);
      term     = (m_sym == 0) ? 24 : v.pairs;
      exp_end  = exp_run & pmv & (m_pairs == term - 1);
      exp_ss   = exp_run & m_first;
      exp_done = m_done_next;
      if (pif.run !== exp_run)  run_mm++;
      if (sym_start !== exp_ss) ss_mm++;
      if (sym_end !== exp_end)  se_mm++;
      if (done !== exp_done)    done_mm++;
      if (rate_err !== 1'b0)    rerr_mm++;
      if (busy !== (m_active | exp_done)) busy_mm++;
      if (m_active && pif.cr !== m_cr) cr_mm++;
      if (m_active && field !== (m_sym != 0)) fld_mm++;
      if (pif.run === 1'b1) runs++;
      if (done === 1'b1) dones++;
      if (sym_end === 1'b1) begin
        if (exp_q.size() == 0) idx_mm++;
        else begin
          e = exp_q.pop_front();
          if (sym_idx !== e) idx_mm++;
        end
      end

      m_done_next = 0;
      if (exp_run) begin
        m_first = 0;
        phase = (phase + 1) % ((m_cr == 2'b01) ? 4 : 3);
        if (pmv) m_pairs++;
        if (exp_end) begin
          m_pairs = 0; m_first = 1; phase = 0; m_sym++;
          if (m_sym > v.n) begin m_active = 0; m_done_next = 1; end
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (!m_active && !m_done_next) begin
        tail++;
        if (tail == 3) break;
      end
    end

    check({tag, "_complete"}, tail, 3);
    check({tag, "_runs"}, runs, v.exp_runs);
    check({tag, "_done_cnt"}, dones, 1);
    check({tag, "_run_mm"}, run_mm, 0);
    check({tag, "_sym_start_mm"}, ss_mm, 0);
    check({tag, "_sym_end_mm"}, se_mm, 0);
    check({tag, "_done_mm"}, done_mm, 0);
    check({tag, "_busy_mm"}, busy_mm, 0);
    check({tag, "_cr_mm"}, cr_mm, 0);
    check({tag, "_field_mm"}, fld_mm, 0);
    check({tag, "_sym_idx_mm"}, idx_mm, 0);
    check({tag, "_rate_err_mm"}, rerr_mm, 0);
    check({tag, "_exp_q_left"}, exp_q.size(), 0);
    @(negedge clk);
    check({tag, "_busy_off"}, busy, 0);
    check({tag, "_field_off"}, field, 0);
    check({tag, "_cr_off"}, pif.cr, 0);
    check({tag, "_state_idle"}, state_dbg, 0);
`ifdef PUNCT_ALIGN_CHECK_EN
    exp_al = v.exp_align;
`else
    exp_al = 1'b0;
`endif
    check({tag, "_align"}, align_err, exp_al);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] bad_rates[2];
    int         dcnt;
    bit         exp_al;
    // rate   n  P    crD    mode force poke runs align
    vecs[0] = '{4'b1101, 2, 24,  2'b00, 0, 1'b0, 1'b1, 72,  1'b0};
    vecs[1] = '{4'b0011, 1, 144, 2'b10, 0, 1'b0, 1'b0, 240, 1'b0};
    vecs[2] = '{4'b0001, 3, 144, 2'b01, 1, 1'b0, 1'b0, 600, 1'b0};
    vecs[3] = '{4'b0101, 0, 48,  2'b00, 0, 1'b0, 1'b0, 24,  1'b0};
    vecs[4] = '{4'b1111, 1, 24,  2'b10, 0, 1'b0, 1'b0, 60,  1'b0};
    vecs[5] = '{4'b1001, 1, 96,  2'b00, 2, 1'b0, 1'b0, 120, 1'b0};
    vecs[6] = '{4'b1011, 2, 96,  2'b10, 0, 1'b0, 1'b1, 312, 1'b0};
    vecs[7] = '{4'b0111, 1, 48,  2'b10, 0, 1'b1, 1'b0, 72,  1'b1};
    bad_rates[0] = 4'b0000;
    bad_rates[1] = 4'b1110;

    rst = 1'b1; rate = 4'd0; n_sym = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    pif.src_ready = 1'b1; pif.dn_ready = 1'b1; pif.pm_valid = 1'b1;
    @(negedge clk);
    check("rst_run", pif.run, 0);
    check("rst_sym_start", sym_start, 0);
    check("rst_sym_end", sym_end, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_field", field, 0);
    check("rst_cr", pif.cr, 0);
    check("rst_sym_idx", sym_idx, 0);
    check("rst_rate_err", rate_err, 0);
    check("rst_align_err", align_err, 0);
    check("rst_state", state_dbg, 0);
    @(posedge clk); #1;

    // invalid rate codes: one-cycle rate_err, no frame
    foreach (bad_rates[i]) begin
      start = 1'b1; rate = bad_rates[i]; n_sym = NSYM_W'(3);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("rate_err_pulse", rate_err, 1);
      check("rate_err_busy", busy, 0);
      check("rate_err_state", state_dbg, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rate_err_clear", rate_err, 0);
      check("rate_err_busy2", busy, 0);
      @(posedge clk); #1;
    end

    foreach (vecs[i]) run_frame(vecs[i], $sformatf("v%0d", i));

    // align_err holds after the frame until the next accepted start
    repeat (5) @(posedge clk);
    @(negedge clk);
`ifdef PUNCT_ALIGN_CHECK_EN
    exp_al = 1'b1;
`else
    exp_al = 1'b0;
`endif
    check("align_sticky", align_err, exp_al);
    @(posedge clk); #1;
    run_frame(vecs[4], "after_align");

    // reset in the middle of a DATA symbol (pair_cnt = 50)
    start = 1'b1; rate = 4'b1001; n_sym = NSYM_W'(2);
    pif.src_ready = 1'b1; pif.dn_ready = 1'b1; pif.pm_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (74) @(posedge clk);
    #1;
    check("mid_state_data", state_dbg, 2);
    check("mid_field", field, 1);
    check("mid_sym_idx", sym_idx, 0);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_run", pif.run, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_field", field, 0);
    check("mid_rst_cr", pif.cr, 0);
    check("mid_rst_sym_idx", sym_idx, 0);
    check("mid_rst_state", state_dbg, 0);
    check("mid_rst_sym_end", sym_end, 0);
    dcnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (done === 1'b1) dcnt++;
      @(negedge clk);
    end
    check("mid_rst_no_done", dcnt, 0);
    @(posedge clk); #1;
    run_frame(vecs[5], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
